// File: rtl/mem_responder_if.sv
// Memory-port bundle between the control unit (master) and the memory responder (slave).
`timescale 1ns/1ps
interface mem_responder_if;
    logic        Read;
    logic        Write;
    logic [31:0] MAR_addr;
    logic [31:0] MDR_data;
    logic [31:0] Mdatain;
    logic        Ready;
    logic        busy;
    logic        err;

    modport master (
        output Read, Write, MAR_addr, MDR_data,
        input  Mdatain, Ready, busy, err
    );

    modport slave (
        input  Read, Write, MAR_addr, MDR_data,
        output Mdatain, Ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed synchronous memory answering the MAR/MDR port through a four-phase
// Read/Write-Ready handshake with a fixed number of wait states.
`timescale 1ns/1ps
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic            clock,
    input  logic            clear,
    mem_responder_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    logic [1:0]            state_q,   state_d;
    logic [3:0]            cnt_q,     cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic                  oor_q,     oor_d;
    logic                  wr_q,      wr_d;
    logic [31:0]           wdata_q,   wdata_d;
    logic [31:0]           mdatain_q, mdatain_d;
    logic                  ready_q,   ready_d;
    logic                  err_q,     err_d;
    logic                  busy_q,    busy_d;

    logic [31:0]           mem_q [DEPTH];

    logic                  oor_in_s;
    logic                  access_s;
    logic                  mem_we_s;

    // Any address bit above the array range makes the request out of range, never aliased.
    assign oor_in_s = |bus.MAR_addr[31:ADDR_WIDTH];
    assign access_s = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we_s = access_s && wr_q && !oor_q;

    // Next-state and output computation for the handshake FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        oor_d     = oor_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        mdatain_d = mdatain_q;
        ready_d   = ready_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Read ^ bus.Write) begin
                    addr_d  = bus.MAR_addr[ADDR_WIDTH-1:0];
                    oor_d   = oor_in_s;
                    wr_d    = bus.Write;
                    wdata_d = bus.MDR_data;
                    cnt_d   = WS_LOAD;
                    state_d = S_WAIT;
                end else if (bus.Read && bus.Write) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    err_d   = oor_q;
                    state_d = S_RESP;
                    if (!wr_q) begin
                        mdatain_d = oor_q ? 32'd0 : mem_q[addr_q];
                    end else begin
                        mdatain_d = mdatain_q;
                    end
                end
            end
            S_RESP: begin
                if (!bus.Read && !bus.Write) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_DROP;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_DROP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            oor_q     <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= 32'd0;
            mdatain_q <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            oor_q     <= oor_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            mdatain_q <= mdatain_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Storage array; left unreset, and held idle by the FSM while clear is low.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.Mdatain = mdatain_q;
    assign bus.Ready   = ready_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed synchronous memory that acts as the responder to the datapath's MAR/MDR memory port. It services read and write requests issued by the control unit through a four-phase Read/Write–Ready handshake, with a configurable number of wait states. Read data is returned on `Mdatain`, which feeds the MDR's memory-side input. Write data is taken from the MDR output.

## Interface
- `ADDR_WIDTH`, 9: number of word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 2: extra cycles between sampling a request and performing the access; legal range 0..15.

- `clock`  in  1  rising-edge clock; the only clock.
- `clear`  in  1  reset, asynchronous, active-low.
- `Read`  in  1  read request (level).
- `Write`  in  1  write request (level).
- `MAR_addr`  in  32  word address (MAR output).
- `MDR_data`  in  32  write data (MDR output).
- `Mdatain`  out  32  read data, registered; drives the MDR memory input.
- `Ready`  out  1  access complete; held until the request drops.
- `busy`  out  1  high while not in IDLE.
- `err`  out  1  qualifies `Ready`; high when the completed request was rejected.

## Operation
- States: IDLE, WAIT, RESP, DROP.
- **IDLE**
  - A request is sampled when exactly one of `Read`/`Write` is high.
  - On that edge: latch the address and, for writes, the data; load the counter with WAIT_STATES; go to WAIT.
- **WAIT**
  - Counter > 0: decrement, stay in WAIT.
  - Counter = 0: perform the access on this edge, set `Ready`=1, go to RESP.
- **Access rules**
  - Read: `Mdatain` <= mem[addr].
  - Write: mem[addr] <= latched data; `Mdatain` unchanged.
- **Errors**
  - Out of range: any of `MAR_addr[31:ADDR_WIDTH]` nonzero. There is no array access, `err`=1 with `Ready`, and on a read `Mdatain` <= 0.
  - Conflict: `Read` and `Write` both high in IDLE. Go directly to RESP on that edge with `Ready`=1 and `err`=1; no access.
- **RESP**
  - `Ready`/`err` are held while `Read` or `Write` stays high.
  - When both are low: clear `Ready` and `err`, go to DROP.
- **DROP**
  - Go to IDLE unconditionally.
  - Guarantees at least one idle cycle between transactions; a request present in DROP is not sampled until IDLE.
- Request changes during WAIT are ignored. The address and data latched in IDLE are used.
- `Mdatain` holds its value from one read completion until the next read completion or reset.
- The memory array is not reset. Contents are undefined until written.

## Timing
- Reset (`clear`=0, asynchronous): state IDLE, `Ready`=0, `err`=0, `busy`=0, `Mdatain`=0, counter 0.
- Reset mid-transaction aborts it. A write is committed only if its access edge occurred before `clear` fell.
- Latency, with the request sampled at edge 0: access and `Ready`=1 after edge WAIT_STATES+1 (edge 1 when WAIT_STATES=0).
- Conflict latency: `Ready`=1, `err`=1 after edge 0.
- `Ready` deassertion: after the first edge at which `Read`=`Write`=0 in RESP.
- Earliest next sample: the second edge after `Ready` drops (one DROP cycle).
- `busy` = (state ≠ IDLE), registered with state. It is high from edge 0 through the DROP cycle.
- `Mdatain` is valid in the same cycle `Ready` rises and stays stable while `Ready`=1.

## Test plan
- **Reset:**
  - Stimulus: `clear`=0 during a WAIT with `Mdatain`=0xDEADBEEF.
  - Required: all outputs are 0 immediately (before the next edge); state is IDLE.
- **Write then read, WAIT_STATES=2:**
  - Stimulus: write 0x12345678 to address 5, then read address 5.
  - Required: `Ready` rises after edge 3 of each transaction; the read returns `Mdatain`=0x12345678; `err`=0.
- **Handshake hold:**
  - Stimulus: hold `Read` 4 cycles past `Ready`.
  - Required: `Ready` stays 1 and `Mdatain` is stable; `Ready` falls 1 edge after `Read` drops; `busy` falls 1 edge later.
- **Out of range, ADDR_WIDTH=9:**
  - Stimulus: write 0xAAAA5555 to address 0x200, then read address 0x000 (previously holding 0x11).
  - Required: the write completes with `err`=1; the following read returns 0x11, showing no aliasing.
  - Then read address 0x200: `Mdatain`=0, `err`=1.
- **Conflict:**
  - Stimulus: `Read`=`Write`=1 in IDLE.
  - Required: `Ready`=`err`=1 after edge 0; memory unchanged; `Mdatain` unchanged.
- **Back-to-back and WAIT_STATES=0:**
  - Stimulus: reads of addresses 1, 2, 3 issued as soon as `busy` falls.
  - Required: each `Ready` rises after edge 1; there are exactly 4 edges between consecutive samples, with 1 RESP cycle per handshake plus the DROP cycle; data matches preload values.
